reaction_ctrl: RTL and testbench
================================

// Module: reaction_ctrl
// PURPOSE
//  Round controller for the reaction-time test; sits directly upstream of the ms timer.
//  Synchronises and debounces the player button, then waits a pseudo-random delay and lights the stimulus LED.
//  Drives the timer's clear/start/stop strobes and flags false starts and timeouts.
//  Outputs feed the timer and the display/result logic.
// PARAMETERS
//  CLK_PER_MS        100000  clk cycles per millisecond (delay-countdown tick)
//  DB_CYCLES         100000  cycles button level must be stable before accepted (>=1)
//  MIN_DELAY_MS      1000    fixed part of stimulus delay, ms
//  DELAY_RANGE_LOG2  12      random part = LFSR[DELAY_RANGE_LOG2-1:0] ms (0..4095)
//  TIMEOUT_MS        9999    ms_time value treated as no-response timeout
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous, active-low reset
//  btn          in   1   raw player button, active-high, asynchronous to clk
//  ms_time      in   14  elapsed ms from the timer
//  timer_clr    out  1   1-cycle active-high pulse; clears the timer
//  start        out  1   1-cycle pulse; timer begins counting
//  stop         out  1   1-cycle pulse; timer freezes
//  led          out  1   stimulus lamp, high only in RUN
//  false_start  out  1   sticky; button pressed during WAIT this round
//  timeout      out  1   sticky; ms_time reached TIMEOUT_MS in RUN
//  result_valid out  1   high in DONE when neither flag set (ms_time is a valid score)
//  state        out  3   FSM encoding: IDLE=0 ARM=1 WAIT=2 RUN=3 DONE=4 FAULT=5
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; all outputs 0; LFSR=16'hACE1; all counters 0.
//  Button path: 2-flop sync -> debounce counter (clears on level change; accepts level after DB_CYCLES equal samples).
//   press = 1-cycle pulse on debounced 0->1 transition.
//   Latency from raw edge = 2 + DB_CYCLES + 1 cycles. Release generates no pulse.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clk in every state; never zero.
//  FSM (all transitions registered; pulses are asserted for the single cycle of entry):
//   IDLE:  press -> ARM.
//   ARM:   one cycle only. Assert timer_clr; clear false_start/timeout.
//          Load delay_ms = MIN_DELAY_MS + LFSR[DELAY_RANGE_LOG2-1:0] (16-bit, no overflow at defaults).
//          Clear ms tick counter. -> WAIT.
//   WAIT:  tick counter 0..CLK_PER_MS-1; on wrap, delay_ms decrements.
//          press -> FAULT with false_start=1; press has priority over expiry in the same cycle.
//          delay_ms==0 at wrap -> RUN.
//   RUN:   led=1; start pulsed on entry cycle.
//          press -> DONE with stop pulse.
//          Else ms_time>=TIMEOUT_MS -> DONE with stop pulse and timeout=1.
//          Press and timeout in the same cycle: press wins, timeout=0.
//   DONE:  led=0; result_valid=!timeout. press -> ARM (new round).
//   FAULT: led=0; start never issued this round. press -> ARM.
//  Exactly one of start/stop/timer_clr may be high in any cycle.
//  A press already in flight when leaving a state is consumed there; it is not queued.
//  Reset mid-round: immediate return to IDLE; led, all strobes and all flags drop asynchronously.
// TESTING (params CLK_PER_MS=10, DB_CYCLES=4, MIN_DELAY_MS=2, DELAY_RANGE_LOG2=2)
//  Reset then hold btn high 20 cycles -> exactly one press; IDLE->ARM (timer_clr 1 cycle) -> WAIT;
//   delay_ms = 2 + LFSR[1:0] at ARM.
//  Let delay expire, no button -> RUN after (delay_ms+1)*10 cycles ±1; start and led rise in the same cycle;
//   press -> stop 1 cycle, DONE, result_valid=1.
//  Press during WAIT -> FAULT, false_start=1, led never high, start never pulsed;
//   next press -> ARM clears false_start.
//  Bounce: btn toggles every 2 cycles for 30 cycles then settles high -> single press pulse only.
//  In RUN, drive ms_time=9999 -> stop pulse, DONE, timeout=1, result_valid=0.
//   Drive ms_time=9999 in the same cycle as a press -> timeout=0.
//  Assert rst_n=0 in RUN -> led, flags and state go to 0 without a clock edge; LFSR reloads 16'hACE1.

Source files
------------

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: reaction-time round controller; debounces the button, waits a random delay, drives the timer strobes and flags.
// Ports: clk, rst_n (async active-low); btn raw button; ms_time elapsed ms from timer;
//        timer_clr/start/stop 1-cycle strobes to the timer; led stimulus lamp;
//        false_start/timeout sticky round flags; result_valid score valid in DONE; state FSM encoding.
module reaction_ctrl #(
  parameter int CLK_PER_MS       = 100000,
  parameter int DB_CYCLES        = 100000,
  parameter int MIN_DELAY_MS     = 1000,
  parameter int DELAY_RANGE_LOG2 = 12,
  parameter int TIMEOUT_MS       = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn,
  input  logic [13:0] ms_time,
  output logic        timer_clr,
  output logic        start,
  output logic        stop,
  output logic        led,
  output logic        false_start,
  output logic        timeout,
  output logic        result_valid,
  output logic [2:0]  state
);
  localparam int TW = $clog2(CLK_PER_MS + 1);
  localparam int DW = $clog2(DB_CYCLES + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, ARM = 3'd1, WAIT = 3'd2, RUN = 3'd3, DONE = 3'd4, FAULT = 3'd5} state_t;
  state_t        state_q;
  logic [1:0]    sync_q;
  logic          db_q, press_q;
  logic [DW-1:0] db_cnt_q;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [15:0]   delay_q;
  logic [TW-1:0] tick_q;
  logic          clr_q, start_q, stop_q, led_q, fs_q, to_q, rv_q;
  assign lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign state        = state_q;
  assign timer_clr    = clr_q;
  assign start        = start_q;
  assign stop         = stop_q;
  assign led          = led_q;
  assign false_start  = fs_q;
  assign timeout      = to_q;
  assign result_valid = rv_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= 16'hACE1;
    else lfsr_q <= lfsr_d;
  // A new level is accepted only after DB_CYCLES consecutive samples differ from the
  // current debounced level; any return to the old level restarts the count.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q   <= 2'b00;
      db_q     <= 1'b0;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      press_q <= 1'b0;
      if (sync_q[1] == db_q) db_cnt_q <= '0;
      else if (db_cnt_q == DW'(DB_CYCLES - 1)) begin
        db_q     <= sync_q[1];
        db_cnt_q <= '0;
        press_q  <= sync_q[1];
      end else db_cnt_q <= db_cnt_q + 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      delay_q <= '0;
      tick_q  <= '0;
      clr_q   <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      led_q   <= 1'b0;
      fs_q    <= 1'b0;
      to_q    <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      clr_q   <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      case (state_q)
        IDLE, DONE, FAULT:
          if (press_q) begin
            state_q <= ARM;
            clr_q   <= 1'b1;
            fs_q    <= 1'b0;
            to_q    <= 1'b0;
            rv_q    <= 1'b0;
          end
        ARM: begin
          state_q <= WAIT;
          delay_q <= 16'(MIN_DELAY_MS) + 16'(lfsr_q[DELAY_RANGE_LOG2-1:0]);
          tick_q  <= '0;
        end
        WAIT:
          if (press_q) begin
            state_q <= FAULT;
            fs_q    <= 1'b1;
          end else if (tick_q == TW'(CLK_PER_MS - 1)) begin
            tick_q <= '0;
            if (delay_q == 16'd0) begin
              state_q <= RUN;
              start_q <= 1'b1;
              led_q   <= 1'b1;
            end else delay_q <= delay_q - 1'b1;
          end else tick_q <= tick_q + 1'b1;
        RUN:
          if (press_q || ms_time >= 14'(TIMEOUT_MS)) begin
            state_q <= DONE;
            stop_q  <= 1'b1;
            led_q   <= 1'b0;
            to_q    <= !press_q;
            rv_q    <= press_q;
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_reaction_ctrl.sv
// tb_reaction_ctrl: randomized self-checking bench for reaction_ctrl against a rule-level reference model.
module tb_reaction_ctrl;
  localparam int CPM = 10, DB = 4, MIN = 2, RL = 2;
  logic        clk = 1'b0, rst_n = 1'b1, btn = 1'b0;
  logic [13:0] ms_time = '0;
  logic        timer_clr, start, stop, led, false_start, timeout, result_valid;
  logic [2:0]  state;
  int          n_vec = 0, n_err = 0;
  int          cyc, wait_len, exp_delay, exp_w, arms = 0, a0;
  logic [2:0]  prev;
  logic [15:0] tmp;
  bit          started;
  always #5 clk = ~clk;
  reaction_ctrl #(.CLK_PER_MS(CPM), .DB_CYCLES(DB), .MIN_DELAY_MS(MIN), .DELAY_RANGE_LOG2(RL), .TIMEOUT_MS(9999)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .ms_time(ms_time), .timer_clr(timer_clr), .start(start), .stop(stop),
    .led(led), .false_start(false_start), .timeout(timeout), .result_valid(result_valid), .state(state)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] l = 16'hACE1;
    for (int i = 0; i < n; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    return l;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst_n) begin
      prev     = 3'd0;
      wait_len = 0;
      started  = 1'b0;
    end else begin
      chk("strobe_onehot", 32'($countones({start, stop, timer_clr}) <= 1), 32'd1);
      chk("led_run", 32'(led), 32'(state == 3'd3));
      chk("rv_done", 32'(result_valid), 32'(state == 3'd4 && !timeout));
      if (state == 3'd1 && prev != 3'd1) begin
        arms++;
        started   = 1'b0;
        tmp       = lfsr_at(cyc);
        exp_delay = MIN + int'(tmp[1:0]);
        chk("arm_clr", 32'(timer_clr), 32'd1);
        chk("arm_flags", 32'({false_start, timeout}), 32'd0);
      end
      if (start) started = 1'b1;
      if (prev == 3'd1) chk("arm_next", 32'(state), 32'd2);
      if (state == 3'd2) wait_len = (prev == 3'd2) ? wait_len + 1 : 1;
      if (state == 3'd3 && prev == 3'd2) begin
        exp_w = (exp_delay + 1) * CPM;
        chk("wait_len", 32'(wait_len), 32'((wait_len >= exp_w - 1 && wait_len <= exp_w + 1) ? wait_len : exp_w));
        chk("run_start", 32'(start), 32'd1);
      end
      if (state == 3'd3 && prev == 3'd3) chk("start_once", 32'(start), 32'd0);
      if (state == 3'd5 && prev == 3'd2) begin
        chk("fs_flag", 32'(false_start), 32'd1);
        chk("fs_nostart", 32'(started), 32'd0);
      end
      if (state == 3'd4 && prev == 3'd3) chk("done_stop", 32'(stop), 32'd1);
      prev = state;
    end
  task automatic wait_st(input logic [2:0] s, input int budget, input string tag);
    for (int i = 0; i < budget && state !== s; i++) @(negedge clk);
    chk(tag, 32'(state), 32'(s));
  endtask
  task automatic press();
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_outs"}, 32'({timer_clr, start, stop, led, false_start, timeout, result_valid}), 32'd0);
    chk({tag, "_lfsr"}, 32'(dut.lfsr_q), 32'h0000ACE1);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #1 chk_reset("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a0 = arms;
    btn = 1'b1;
    repeat (20) @(negedge clk);
    btn = 1'b0;
    repeat (8) @(negedge clk);
    chk("hold_one_press", 32'(arms - a0), 32'd1);
    chk("hold_in_wait", 32'(state), 32'd2);
    wait_st(3'd3, 100, "first_run");
    ms_time = 14'($urandom_range(0, 9998));
    repeat ($urandom_range(0, 20)) @(negedge clk);
    press();
    wait_st(3'd4, 20, "first_done");
    chk("first_rv", 32'(result_valid), 32'd1);
    chk("first_to", 32'(timeout), 32'd0);
    for (int r = 0; r < 9; r++) begin
      int k = $urandom_range(0, 2);
      press();
      chk("rnd_wait", 32'(state), 32'd2);
      if (k == 0) begin
        repeat ($urandom_range(0, 8)) @(negedge clk);
        press();
        wait_st(3'd5, 20, "rnd_fault");
        chk("rnd_fs", 32'(false_start), 32'd1);
      end else begin
        wait_st(3'd3, 100, "rnd_run");
        ms_time = 14'($urandom_range(0, 9998));
        repeat ($urandom_range(0, 20)) @(negedge clk);
        if (k == 1) begin
          press();
          wait_st(3'd4, 20, "rnd_done");
          chk("rnd_rv", 32'(result_valid), 32'd1);
        end else begin
          ms_time = 14'd9999;
          @(negedge clk);
          chk("tmo_state", 32'(state), 32'd4);
          chk("tmo_flag", 32'(timeout), 32'd1);
          chk("tmo_rv", 32'(result_valid), 32'd0);
          ms_time = '0;
        end
      end
    end
    press();
    wait_st(3'd3, 100, "tie_run");
    btn = 1'b1;
    for (int i = 0; i < 20 && !dut.press_q; i++) @(negedge clk);
    chk("tie_press_seen", 32'(dut.press_q), 32'd1);
    ms_time = 14'd9999;
    @(negedge clk);
    ms_time = '0;
    chk("tie_state", 32'(state), 32'd4);
    chk("tie_to", 32'(timeout), 32'd0);
    chk("tie_rv", 32'(result_valid), 32'd1);
    repeat (4) @(negedge clk);
    btn = 1'b0;
    repeat (8) @(negedge clk);
    press();
    wait_st(3'd3, 100, "mid_run");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    a0 = arms;
    for (int i = 0; i < 15; i++) begin
      btn = ~btn;
      repeat (2) @(negedge clk);
    end
    chk("bounce_idle", 32'(state), 32'd0);
    btn = 1'b1;
    repeat (20) @(negedge clk);
    btn = 1'b0;
    repeat (4) @(negedge clk);
    chk("bounce_one_press", 32'(arms - a0), 32'd1);
    chk("bounce_wait", 32'(state), 32'd2);
    wait_st(3'd3, 100, "bounce_run");
    press();
    wait_st(3'd4, 20, "bounce_done");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
